// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic {
        LD_LOAD,
        LD_DONE
    } ld_state_e;

    localparam logic [31:0] LD_END_WORD       = 32'hFFFF_FFFF;
    localparam int          LD_BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_imem_loader_if.sv
// Byte stream in from the UART receiver, word writes out to imem.
interface uart_imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_break;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output rx_valid, rx_data, rx_break,
        input  imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data, rx_break,
        output imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/uart_imem_loader_byte_packer.sv
// Packs bytes LSB-first into 32-bit words; drops a partial word
// on break or inter-byte timeout.
module byte_packer
    import loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_en,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        i_break,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    output logic        o_drop
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
    localparam logic [1:0] LAST = 2'(LD_BYTES_PER_WORD - 1);

    logic [1:0]    r_cnt;
    logic [23:0]   r_lanes;
    logic [TW-1:0] r_tmo;
    logic          w_busy;
    logic          w_take;
    logic          w_tmo_hit;

    assign w_busy    = (r_cnt != 2'd0);
    assign w_take    = i_en & i_valid & ~i_break;
    // A byte arriving on the expiry cycle still wins over the timeout.
    assign w_tmo_hit = i_en & ~i_break & ~i_valid & w_busy
                     & (r_tmo == TMO_MAX);

    assign o_word       = {i_data, r_lanes};
    assign o_word_valid = w_take & (r_cnt == LAST);
    assign o_drop       = (i_en & i_break & w_busy) | w_tmo_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= 2'd0;
            r_lanes <= 24'd0;
            r_tmo   <= '0;
        end else if (i_en) begin
            if (i_break || w_tmo_hit) begin
                r_cnt <= 2'd0;
                r_tmo <= '0;
            end else if (i_valid) begin
                case (r_cnt)
                    2'd0:    r_lanes[7:0]   <= i_data;
                    2'd1:    r_lanes[15:8]  <= i_data;
                    2'd2:    r_lanes[23:16] <= i_data;
                    default: ;
                endcase
                r_cnt <= r_cnt + 2'd1;
                r_tmo <= '0;
            end else if (w_busy) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end
endmodule

// File: rtl/uart_imem_loader.sv
// Loads a UART byte stream into imem and holds the core in reset
// until the terminator word arrives.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] END_WORD    = LD_END_WORD,
    parameter int          TIMEOUT_CYC = 200000
) (
    input  logic                clk,
    input  logic                resetn,
    uart_imem_loader_if.slave   bus,
    output logic                write_done,
    output logic                cpu_resetn,
    output logic [ADDR_W:0]     word_count,
    output logic                overflow,
    output logic                frame_err
);
    ld_state_e         r_state;
    ld_state_e         w_state_nx;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic              r_ovf;
    logic              r_ferr;
    logic [31:0]       w_word;
    logic              w_word_valid;
    logic              w_drop;
    logic              w_load;
    logic              w_full;
    logic              w_end;
    logic              w_wr;
    logic              w_ovf_set;

    assign w_load = (r_state == LD_LOAD);
    assign w_full = r_ptr[ADDR_W];
    assign w_end  = (w_word == END_WORD);

    byte_packer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_packer (
        .clk          (clk),
        .resetn       (resetn),
        .i_en         (w_load),
        .i_valid      (bus.rx_valid),
        .i_data       (bus.rx_data),
        .i_break      (bus.rx_break),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_drop       (w_drop)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= LD_LOAD;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_wr       = 1'b0;
        w_ovf_set  = 1'b0;
        if (w_load && w_word_valid) begin
            unique case (1'b1)
                w_end: w_state_nx = LD_DONE;
                (!w_end && w_full): begin
                    w_state_nx = LD_DONE;
                    w_ovf_set  = 1'b1;
                end
                (!w_end && !w_full): w_wr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr   <= '0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_ovf   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_we <= w_wr;
            if (w_wr) begin
                r_addr  <= r_ptr[ADDR_W-1:0];
                r_wdata <= w_word;
                r_ptr   <= r_ptr + 1'b1;
            end
            if (w_ovf_set) r_ovf  <= 1'b1;
            if (w_drop)    r_ferr <= 1'b1;
        end
    end

    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign write_done     = (r_state == LD_DONE);
    assign cpu_resetn     = write_done;
    assign word_count     = r_ptr;
    assign overflow       = r_ovf;
    assign frame_err      = r_ferr;
endmodule
